// File: rtl/host_byte_bridge_if.sv
// ============================================================================
// host_byte_bridge_if : host byte link and core cmd/in/out channel bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface host_byte_bridge_if #(
    parameter int CMD_W = 16
);
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready;
    logic [CMD_W-1:0] cmd;
    logic             cmd_hasAny;
    logic             cmd_consume;
    logic [63:0]      core_in;
    logic             core_in_isReady;
    logic             core_in_canReceive;
    logic [63:0]      core_out;
    logic             core_out_isReady;
    logic             core_out_canReceive;
    logic             busy;

    // master = the bridge, slave = host link plus core
    modport master (
        input  rx_byte, rx_valid, tx_ready, cmd_consume,
               core_in_canReceive, core_out, core_out_isReady,
        output rx_ready, tx_byte, tx_valid, cmd, cmd_hasAny,
               core_in, core_in_isReady, core_out_canReceive, busy
    );

    modport slave (
        output rx_byte, rx_valid, tx_ready, cmd_consume,
               core_in_canReceive, core_out, core_out_isReady,
        input  rx_ready, tx_byte, tx_valid, cmd, cmd_hasAny,
               core_in, core_in_isReady, core_out_canReceive, busy
    );
endinterface

`default_nettype wire

// File: rtl/host_byte_bridge.sv
// ============================================================================
// host_byte_bridge : parses host opcode frames into core cmd/in/out traffic
// Revision: 1.0
// ============================================================================
`default_nettype none

module host_byte_bridge #(
    parameter int          CMD_W    = 16,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    host_byte_bridge_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CMD_LO    = 4'd1,
        S_CMD_HI    = 4'd2,
        S_CMD_ISSUE = 4'd3,
        S_WR_CNT    = 4'd4,
        S_WR_BYTES  = 4'd5,
        S_WR_ISSUE  = 4'd6,
        S_RD_CNT    = 4'd7,
        S_RD_WAIT   = 4'd8,
        S_RD_BYTES  = 4'd9,
        S_ERR       = 4'd10
    } state_t;

    state_t           state_q;
    logic [7:0]       cmd_lo_q;
    logic [CMD_W-1:0] cmd_q;
    logic             cmd_hasAny_q;
    logic [63:0]      shreg_q;
    logic [63:0]      core_in_q;
    logic             core_in_isReady_q;
    logic             core_out_canReceive_q;
    logic [8:0]       words_left_q;
    logic [2:0]       byte_idx_q;
    logic             rx_ready_q;
    logic [7:0]       tx_byte_q;
    logic             tx_valid_q;

    logic        rx_fire;
    logic [15:0] cmd_full;
    logic [8:0]  n_words;

    assign rx_fire  = bus.rx_valid & rx_ready_q;
    assign cmd_full = {bus.rx_byte, cmd_lo_q};
    // A count byte of zero stands for the full 256-word burst
    assign n_words  = (bus.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus.rx_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= S_IDLE;
            cmd_lo_q              <= 8'd0;
            cmd_q                 <= '0;
            cmd_hasAny_q          <= 1'b0;
            shreg_q               <= 64'd0;
            core_in_q             <= 64'd0;
            core_in_isReady_q     <= 1'b0;
            core_out_canReceive_q <= 1'b0;
            words_left_q          <= 9'd0;
            byte_idx_q            <= 3'd0;
            rx_ready_q            <= 1'b0;
            tx_byte_q             <= 8'd0;
            tx_valid_q            <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_fire) begin
                        case (bus.rx_byte)
                            8'h01:   state_q <= S_CMD_LO;
                            8'h02:   state_q <= S_WR_CNT;
                            8'h03:   state_q <= S_RD_CNT;
                            default: begin
                                state_q    <= S_ERR;
                                rx_ready_q <= 1'b0;
                                tx_valid_q <= 1'b1;
                                tx_byte_q  <= ERR_BYTE;
                            end
                        endcase
                    end else begin
                        // first IDLE cycle after reset release opens the link
                        rx_ready_q <= 1'b1;
                    end
                end
                S_CMD_LO: begin
                    if (rx_fire) begin
                        cmd_lo_q <= bus.rx_byte;
                        state_q  <= S_CMD_HI;
                    end
                end
                S_CMD_HI: begin
                    if (rx_fire) begin
                        cmd_q        <= cmd_full[CMD_W-1:0];
                        cmd_hasAny_q <= 1'b1;
                        rx_ready_q   <= 1'b0;
                        state_q      <= S_CMD_ISSUE;
                    end
                end
                S_CMD_ISSUE: begin
                    if (bus.cmd_consume) begin
                        cmd_q        <= '0;
                        cmd_hasAny_q <= 1'b0;
                        rx_ready_q   <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                S_WR_CNT: begin
                    if (rx_fire) begin
                        words_left_q <= n_words;
                        byte_idx_q   <= 3'd0;
                        state_q      <= S_WR_BYTES;
                    end
                end
                S_WR_BYTES: begin
                    if (rx_fire) begin
                        shreg_q    <= {shreg_q[55:0], bus.rx_byte};
                        byte_idx_q <= byte_idx_q + 3'd1;
                        if (byte_idx_q == 3'd7) begin
                            core_in_q         <= {shreg_q[55:0], bus.rx_byte};
                            core_in_isReady_q <= 1'b1;
                            rx_ready_q        <= 1'b0;
                            state_q           <= S_WR_ISSUE;
                        end
                    end
                end
                S_WR_ISSUE: begin
                    if (bus.core_in_canReceive) begin
                        core_in_q         <= 64'd0;
                        core_in_isReady_q <= 1'b0;
                        rx_ready_q        <= 1'b1;
                        words_left_q      <= words_left_q - 9'd1;
                        state_q           <= (words_left_q == 9'd1) ? S_IDLE : S_WR_BYTES;
                    end
                end
                S_RD_CNT: begin
                    if (rx_fire) begin
                        words_left_q          <= n_words;
                        rx_ready_q            <= 1'b0;
                        core_out_canReceive_q <= 1'b1;
                        state_q               <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.core_out_isReady && core_out_canReceive_q) begin
                        shreg_q               <= bus.core_out;
                        core_out_canReceive_q <= 1'b0;
                        tx_valid_q            <= 1'b1;
                        tx_byte_q             <= bus.core_out[63:56];
                        byte_idx_q            <= 3'd0;
                        state_q               <= S_RD_BYTES;
                    end
                end
                S_RD_BYTES: begin
                    if (bus.tx_ready) begin
                        shreg_q    <= {shreg_q[55:0], 8'd0};
                        tx_byte_q  <= shreg_q[55:48];
                        byte_idx_q <= byte_idx_q + 3'd1;
                        if (byte_idx_q == 3'd7) begin
                            tx_valid_q   <= 1'b0;
                            tx_byte_q    <= 8'd0;
                            words_left_q <= words_left_q - 9'd1;
                            if (words_left_q == 9'd1) begin
                                rx_ready_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                core_out_canReceive_q <= 1'b1;
                                state_q               <= S_RD_WAIT;
                            end
                        end
                    end
                end
                S_ERR: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_byte_q  <= 8'd0;
                        rx_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready            = rx_ready_q;
    assign bus.tx_byte             = tx_byte_q;
    assign bus.tx_valid            = tx_valid_q;
    assign bus.cmd                 = cmd_q;
    assign bus.cmd_hasAny          = cmd_hasAny_q;
    assign bus.core_in             = core_in_q;
    assign bus.core_in_isReady     = core_in_isReady_q;
    assign bus.core_out_canReceive = core_out_canReceive_q;
    assign bus.busy                = (state_q != S_IDLE);

endmodule

`default_nettype wire
